// File: rtl/if_id_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register, stall/flush
// statistics and a sticky watchdog for runs of consecutive stall cycles.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             PC_write,
  input  logic             IFID_write,
  input  logic             IF_flush,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      IFID_instr_o,
  output logic [31:0]      IFID_pc4_o,
  output logic             IFID_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             stall_err_o
);

  // Run counter must reach MAX_STALL+1 without overflowing.
  localparam int unsigned     RunW   = $clog2(MAX_STALL + 2);
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_STALL);
  localparam logic [RunW-1:0] RunSat = RunW'(MAX_STALL + 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             err_q, err_d;

  logic [31:0] pc_plus4;
  logic        stall;
  logic        fetch_load;

  assign pc_plus4   = pc_q + 32'd4;
  assign stall      = ~PC_write & ~branch_taken_i;
  assign fetch_load = ~IF_flush & IFID_write;

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    run_d       = run_q;
    err_d       = err_q;

    // Redirect wins even while the hazard detector holds the PC.
    if (branch_taken_i) begin
      pc_d = branch_target_i & ~32'h3;
    end else if (PC_write) begin
      pc_d = pc_plus4;
    end

    if (IF_flush) begin
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (IFID_write) begin
      instr_d = instr_i;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end

    if (stall && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (IF_flush && flush_cnt_q != {CNT_W{1'b1}}) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
    if (fetch_load && fetch_cnt_q != {CNT_W{1'b1}}) begin
      fetch_cnt_d = fetch_cnt_q + 1'b1;
    end

    if (stall) begin
      if (run_q >= RunMax) begin
        run_d = RunSat;
        err_d = 1'b1;
      end else begin
        run_d = run_q + 1'b1;
      end
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fetch_cnt_q <= '0;
      run_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      run_q       <= run_d;
      err_q       <= err_d;
    end
  end

  assign pc_o         = pc_q;
  assign IFID_instr_o = instr_q;
  assign IFID_pc4_o   = pc4_q;
  assign IFID_valid_o = valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign fetch_cnt_o  = fetch_cnt_q;
  assign stall_err_o  = err_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: vector table for the per-edge behaviour, plus
// hand-written sequences for counter saturation and asynchronous reset.
module tb_if_id_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        PC_write = 1'b0;
  logic        IFID_write = 1'b0;
  logic        IF_flush = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [31:0] instr_i = 32'h0;
  logic [31:0] pc_o, IFID_instr_o, IFID_pc4_o;
  logic        IFID_valid_o, stall_err_o;
  logic [3:0]  stall_cnt_o, flush_cnt_o, fetch_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_stage #(
    .RESET_PC (32'h0000_0000),
    .MAX_STALL(2),
    .CNT_W    (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .PC_write       (PC_write),
    .IFID_write     (IFID_write),
    .IF_flush       (IF_flush),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .instr_i        (instr_i),
    .pc_o           (pc_o),
    .IFID_instr_o   (IFID_instr_o),
    .IFID_pc4_o     (IFID_pc4_o),
    .IFID_valid_o   (IFID_valid_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .fetch_cnt_o    (fetch_cnt_o),
    .stall_err_o    (stall_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        pw, iw, fl, br;
    logic [31:0] tgt, instr;
    logic [31:0] pc, ii, pc4;
    logic        v;
    logic [3:0]  sc, fc, fe;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic pw, logic iw, logic fl, logic br, logic [31:0] tgt,
                              logic [31:0] instr, logic [31:0] pc, logic [31:0] ii,
                              logic [31:0] pc4, logic v, logic [3:0] sc, logic [3:0] fc,
                              logic [3:0] fe, logic err);
    vec_t r;
    r.pw = pw; r.iw = iw; r.fl = fl; r.br = br; r.tgt = tgt; r.instr = instr;
    r.pc = pc; r.ii = ii; r.pc4 = pc4; r.v = v; r.sc = sc; r.fc = fc; r.fe = fe;
    r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ii,
                           input logic [31:0] pc4, input logic v, input logic [3:0] sc,
                           input logic [3:0] fc, input logic [3:0] fe, input logic err);
    check({tag, ".pc"},    pc_o, pc);
    check({tag, ".instr"}, IFID_instr_o, ii);
    check({tag, ".pc4"},   IFID_pc4_o, pc4);
    check({tag, ".valid"}, {31'h0, IFID_valid_o}, {31'h0, v});
    check({tag, ".stall"}, {28'h0, stall_cnt_o}, {28'h0, sc});
    check({tag, ".flush"}, {28'h0, flush_cnt_o}, {28'h0, fc});
    check({tag, ".fetch"}, {28'h0, fetch_cnt_o}, {28'h0, fe});
    check({tag, ".err"},   {31'h0, stall_err_o}, {31'h0, err});
  endtask

  task automatic drive(input logic pw, input logic iw, input logic fl, input logic br,
                       input logic [31:0] tgt, input logic [31:0] instr);
    PC_write = pw; IFID_write = iw; IF_flush = fl; branch_taken_i = br;
    branch_target_i = tgt; instr_i = instr;
  endtask

  initial begin
    //           pw iw fl br target        instr         pc            IFinstr  pc4  v  sc fc fe err
    vecs[0]  = mk(1, 1, 0, 0, 32'h0,        32'h11, 32'h4,        32'h11, 32'h4,   1, 0, 0, 1, 0);
    vecs[1]  = mk(1, 1, 0, 0, 32'h0,        32'h22, 32'h8,        32'h22, 32'h8,   1, 0, 0, 2, 0);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,        32'h33, 32'h8,        32'h22, 32'h8,   1, 1, 0, 2, 0);
    vecs[3]  = mk(1, 1, 0, 0, 32'h0,        32'h33, 32'hC,        32'h33, 32'hC,   1, 1, 0, 3, 0);
    vecs[4]  = mk(0, 0, 1, 1, 32'h103,      32'h44, 32'h100,      32'h0,  32'h0,   0, 1, 1, 3, 0);
    vecs[5]  = mk(1, 1, 0, 0, 32'h0,        32'hAA, 32'h104,      32'hAA, 32'h104, 1, 1, 1, 4, 0);
    vecs[6]  = mk(0, 1, 0, 0, 32'h0,        32'hBB, 32'h104,      32'hBB, 32'h108, 1, 2, 1, 5, 0);
    vecs[7]  = mk(1, 1, 1, 0, 32'h0,        32'hCC, 32'h108,      32'h0,  32'h0,   0, 2, 2, 5, 0);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,        32'hD0, 32'h108,      32'h0,  32'h0,   0, 3, 2, 5, 0);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,        32'hD0, 32'h108,      32'h0,  32'h0,   0, 4, 2, 5, 0);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,        32'hD0, 32'h108,      32'h0,  32'h0,   0, 5, 2, 5, 1);
    vecs[11] = mk(1, 1, 0, 0, 32'h0,        32'hDD, 32'h10C,      32'hDD, 32'h10C, 1, 5, 2, 6, 1);
    vecs[12] = mk(1, 1, 0, 1, 32'hFFFFFFFF, 32'hEE, 32'hFFFFFFFC, 32'hEE, 32'h110, 1, 5, 2, 7, 1);
    vecs[13] = mk(1, 1, 0, 0, 32'h0,        32'hFF, 32'h0,        32'hFF, 32'h0,   1, 5, 2, 8, 1);

    #7;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    #5 rst_i = 1'b0;  // t=12, between edges

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].instr);
      @(posedge clk_i);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ii, vecs[i].pc4, vecs[i].v,
                vecs[i].sc, vecs[i].fc, vecs[i].fe, vecs[i].err);
    end

    // 20 more stalls from 5 must pin the 4-bit counter at all-ones.
    drive(0, 0, 0, 0, 32'h0, 32'h55);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      if (i == 9) check("stall_at_15", {28'h0, stall_cnt_o}, 32'hF);
    end
    check_all("stall_sat", 32'h0, 32'hFF, 32'h0, 1'b1, 4'hF, 4'h2, 4'h8, 1'b1);

    // Reset asserted between edges while a redirect is being presented.
    drive(0, 0, 1, 1, 32'h200, 32'h66);
    #2 rst_i = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(posedge clk_i);
    #1;
    check_all("rst_held", 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1, 1, 0, 0, 32'h0, 32'h77);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_all("post_rst", 32'h4, 32'h77, 32'h4, 1'b1, 4'h0, 4'h0, 4'h1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
